// File: rtl/fsm_stream_arb.sv
// fsm_stream_arb: arbitrates two serial-packet requesters onto one shared serial FSM and returns its output bits.
// Define FSM_ARB_FIXED_PRIO_EN for fixed priority (req0 always wins ties); the default build is round-robin.
module fsm_stream_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic       din0,
    input  logic       din1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rd0,
    output logic       rd1,
    output logic       fsm_rst,
    output logic       fsm_x,
    input  logic       fsm_y,
    output logic       dout,
    output logic       dout_vld,
    output logic       dout_id,
    output logic       done0,
    output logic       done1
);

    typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_GAP} state_t;

    state_t     r_state;
    logic       r_win;
    logic [3:0] r_cnt;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_rd0;
    logic       r_rd1;
    logic       r_fsm_rst;
    logic       r_dout;
    logic       r_dout_vld;
    logic       r_dout_id;
    logic       r_done0;
    logic       r_done1;

    logic       w_pick;
    logic       w_win_req;
    logic       w_win_din;

    assign w_win_req = r_win ? req1 : req0;
    assign w_win_din = r_win ? din1 : din0;

`ifdef FSM_ARB_FIXED_PRIO_EN
    assign w_pick = ~req0;
`else
    logic r_last;

    // Tie goes to whoever was not served last; a lone request always wins.
    assign w_pick = (req0 & req1) ? ~r_last : req1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= 1'b1;
        end else if (r_state == S_GAP) begin
            r_last <= r_win;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_win      <= 1'b0;
            r_cnt      <= 4'd0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rd0      <= 1'b0;
            r_rd1      <= 1'b0;
            r_fsm_rst  <= 1'b0;
            r_dout     <= 1'b0;
            r_dout_vld <= 1'b0;
            r_dout_id  <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
        end else begin
            // NOTE: one-cycle pulses default low here and are raised only by the arm that needs them;
            // non-blocking assignments keep every arm working from the pre-edge values.
            r_fsm_rst  <= 1'b0;
            r_dout_vld <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req0 | req1) begin
                        r_state   <= S_CLR;
                        r_win     <= w_pick;
                        r_cnt     <= w_pick ? len1 : len0;
                        r_fsm_rst <= 1'b1;
                        r_gnt0    <= ~w_pick;
                        r_gnt1    <= w_pick;
                    end
                end
                S_CLR: begin
                    if (!w_win_req) begin
                        r_state <= S_GAP;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                    end else begin
                        r_state <= S_RUN;
                        r_rd0   <= ~r_win;
                        r_rd1   <= r_win;
                    end
                end
                S_RUN: begin
                    r_dout     <= fsm_y;
                    r_dout_vld <= 1'b1;
                    r_dout_id  <= r_win;
                    if (!w_win_req || (r_cnt == 4'd0)) begin
                        // An abandoned packet ends without a completion pulse.
                        r_state <= S_GAP;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        r_rd0   <= 1'b0;
                        r_rd1   <= 1'b0;
                        r_done0 <= w_win_req & ~r_win;
                        r_done1 <= w_win_req & r_win;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign rd0      = r_rd0;
    assign rd1      = r_rd1;
    assign fsm_rst  = r_fsm_rst;
    assign fsm_x    = (r_state == S_RUN) ? w_win_din : 1'b0;
    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign dout_id  = r_dout_id;
    assign done0    = r_done0;
    assign done1    = r_done1;

endmodule

// File: tb/tb_fsm_stream_arb.sv
// tb_fsm_stream_arb: scenario tasks plus a randomized run, checked against a packet-interval model of the arbiter.
// The shared serial FSM is modelled here as a running parity of fsm_x, cleared by fsm_rst.
module tb_fsm_stream_arb;

    logic       clk;
    logic       reset;
    logic       req0;
    logic       req1;
    logic [3:0] len0;
    logic [3:0] len1;
    logic       din0;
    logic       din1;
    logic       gnt0;
    logic       gnt1;
    logic       rd0;
    logic       rd1;
    logic       fsm_rst;
    logic       fsm_x;
    logic       fsm_y;
    logic       dout;
    logic       dout_vld;
    logic       dout_id;
    logic       done0;
    logic       done1;

    int n_vec;
    int n_err;

`ifdef FSM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    fsm_stream_arb dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .len0     (len0),
        .len1     (len1),
        .din0     (din0),
        .din1     (din1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rd0      (rd0),
        .rd1      (rd1),
        .fsm_rst  (fsm_rst),
        .fsm_x    (fsm_x),
        .fsm_y    (fsm_y),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_id  (dout_id),
        .done0    (done0),
        .done1    (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External serial FSM: output is the parity of every x bit since the last restart.
    logic r_par;
    assign fsm_y = r_par ^ fsm_x;
    always @(posedge clk or negedge reset) begin
        if (!reset)       r_par <= 1'b0;
        else if (fsm_rst) r_par <= 1'b0;
        else              r_par <= fsm_y;
    end

    // Packet-interval model: one active packet occupies [m_clr, m_gap]; CLR at m_clr, RUN strictly between, GAP at m_gap.
    int          cyc;
    int          m_clr;
    int          m_gap;
    int          m_len;
    bit          m_act;
    bit          m_win;
    bit          m_last;
    bit          m_abort;
    bit          m_par;
    bit          m_prev_run;
    bit          m_prev_y;
    bit          m_prev_id;
    bit          din_ones;
    logic [10:0] e_vec;

    function automatic logic [10:0] obs_vec();
        return {gnt0, gnt1, rd0, rd1, fsm_rst, fsm_x, dout_vld,
                dout_vld & dout, dout_vld & dout_id, done0, done1};
    endfunction

    task automatic model_reset();
        m_act      = 1'b0;
        m_last     = 1'b1;
        m_abort    = 1'b0;
        m_prev_run = 1'b0;
        m_prev_y   = 1'b0;
        m_prev_id  = 1'b0;
    endtask

    task automatic model_eval();
        logic [1:0] g;
        logic [1:0] r;
        logic [1:0] d;
        logic       fr;
        logic       fx;
        din0 = din_ones ? 1'b1 : 1'($urandom_range(0, 1));
        din1 = din_ones ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        g  = 2'b00;
        r  = 2'b00;
        d  = 2'b00;
        fr = 1'b0;
        fx = 1'b0;
        if (m_act) begin
            if (cyc == m_clr) begin
                fr       = 1'b1;
                g[m_win] = 1'b1;
            end else if (cyc > m_clr && cyc < m_gap) begin
                g[m_win] = 1'b1;
                r[m_win] = 1'b1;
                fx       = m_win ? din1 : din0;
            end else if (cyc == m_gap && !m_abort) begin
                d[m_win] = 1'b1;
            end
        end
        e_vec = {g[0], g[1], r[0], r[1], fr, fx, m_prev_run,
                 m_prev_run & m_prev_y, m_prev_run & m_prev_id, d[0], d[1]};
    endtask

    task automatic advance();
        logic wr;
        logic wd;
        wr = m_win ? req1 : req0;
        wd = m_win ? din1 : din0;
        m_prev_run = m_act && cyc > m_clr && cyc < m_gap;
        if (m_prev_run) begin
            m_par     = m_par ^ wd;
            m_prev_y  = m_par;
            m_prev_id = m_win;
        end
        if (m_act && cyc >= m_clr && cyc < m_gap && !wr) begin
            m_gap   = cyc + 1;
            m_abort = 1'b1;
        end
        if (m_act && cyc == m_gap) m_last = m_win;
        if ((!m_act || cyc > m_gap) && (req0 || req1)) begin
            if (req0 && req1) m_win = FIXED ? 1'b0 : !m_last;
            else              m_win = req1;
            m_len   = m_win ? int'(len1) : int'(len0);
            m_clr   = cyc + 1;
            m_gap   = cyc + m_len + 3;
            m_abort = 1'b0;
            m_par   = 1'b0;
            m_act   = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        len0  = 4'd3;
        len1  = 4'd3;
        din0  = 1'b1;
        din1  = 1'b1;
        #1;
        n_vec++;
        if (obs_vec() !== 11'd0) begin
            n_err++;
            $display("FAIL reset_async got=%b exp=%b", obs_vec(), 11'd0);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (obs_vec() !== 11'd0) begin
                n_err++;
                $display("FAIL reset_hold k=%0d got=%b exp=%b", k, obs_vec(), 11'd0);
            end
        end
        req0  = 1'b0;
        req1  = 1'b0;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        int n_rst  = 0;
        int n_rd   = 0;
        int n_vld  = 0;
        int n_done = 0;
        int t_done = -1;
        bit seen   = 1'b0;
        apply_reset();
        din_ones = 1'b1;
        len0 = 4'd3;
        len1 = 4'd0;
        for (int k = 0; k < 12; k++) begin
            req0 = !seen;
            req1 = 1'b0;
            model_eval();
            n_vec++;
            if (obs_vec() !== e_vec) begin
                n_err++;
                $display("FAIL single k=%0d got=%b exp=%b", k, obs_vec(), e_vec);
            end
            n_rst += int'(fsm_rst);
            n_rd  += int'(rd0);
            if (dout_vld && !dout_id) n_vld++;
            if (done0) begin
                n_done++;
                if (t_done < 0) t_done = k + 1;
                seen = 1'b1;
            end
            advance();
        end
        din_ones = 1'b0;
        n_vec++;
        if (n_rst !== 1) begin n_err++; $display("FAIL single_fsm_rst got=%0d exp=1", n_rst); end
        n_vec++;
        if (n_rd !== 4) begin n_err++; $display("FAIL single_rd0 got=%0d exp=4", n_rd); end
        n_vec++;
        if (n_vld !== 4) begin n_err++; $display("FAIL single_vld got=%0d exp=4", n_vld); end
        n_vec++;
        if (n_done !== 1) begin n_err++; $display("FAIL single_done0 got=%0d exp=1", n_done); end
        n_vec++;
        if (t_done !== 7) begin n_err++; $display("FAIL single_latency got=%0d exp=7", t_done); end
    endtask

    task automatic test_tie();
        bit s0     = 1'b0;
        bit s1     = 1'b0;
        int first  = -1;
        int second = -1;
        int n_both = 0;
        apply_reset();
        len0 = 4'd0;
        len1 = 4'd0;
        for (int k = 0; k < 12; k++) begin
            req0 = !s0;
            req1 = !s1;
            model_eval();
            n_vec++;
            if (obs_vec() !== e_vec) begin
                n_err++;
                $display("FAIL tie k=%0d got=%b exp=%b", k, obs_vec(), e_vec);
            end
            if (gnt0 && gnt1) n_both++;
            if (done0 || done1) begin
                if (first < 0)       first  = done1 ? 1 : 0;
                else if (second < 0) second = done1 ? 1 : 0;
            end
            if (done0) s0 = 1'b1;
            if (done1) s1 = 1'b1;
            advance();
        end
        n_vec++;
        if (first !== 0) begin n_err++; $display("FAIL tie_first got=%0d exp=0", first); end
        n_vec++;
        if (second !== 1) begin n_err++; $display("FAIL tie_second got=%0d exp=1", second); end
        n_vec++;
        if (n_both !== 0) begin n_err++; $display("FAIL tie_both_gnt got=%0d exp=0", n_both); end
    endtask

    task automatic test_round_robin();
        bit grants[$];
        apply_reset();
        len0 = 4'd1;
        len1 = 4'd1;
        for (int k = 0; k < 26; k++) begin
            req0 = 1'b1;
            req1 = 1'b1;
            model_eval();
            n_vec++;
            if (obs_vec() !== e_vec) begin
                n_err++;
                $display("FAIL rr k=%0d got=%b exp=%b", k, obs_vec(), e_vec);
            end
            if (fsm_rst) grants.push_back(gnt1);
            advance();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        n_vec++;
        if (grants.size() !== 5) begin
            n_err++;
            $display("FAIL rr_count got=%0d exp=5", grants.size());
        end
        foreach (grants[i]) begin
            n_vec++;
            if (grants[i] !== (FIXED ? 1'b0 : 1'(i % 2))) begin
                n_err++;
                $display("FAIL rr_grant%0d got=%0d exp=%0d", i, grants[i], FIXED ? 0 : i % 2);
            end
        end
    endtask

    task automatic test_max_len();
        int n_rd   = 0;
        int n_vld  = 0;
        int n_done = 0;
        bit seen   = 1'b0;
        apply_reset();
        len0 = 4'd15;
        for (int k = 0; k < 24; k++) begin
            req0 = !seen;
            req1 = 1'b0;
            model_eval();
            n_vec++;
            if (obs_vec() !== e_vec) begin
                n_err++;
                $display("FAIL maxlen k=%0d got=%b exp=%b", k, obs_vec(), e_vec);
            end
            n_rd += int'(rd0);
            if (dout_vld) n_vld++;
            if (done0) begin
                n_done++;
                seen = 1'b1;
            end
            advance();
        end
        n_vec++;
        if (n_rd !== 16) begin n_err++; $display("FAIL maxlen_rd got=%0d exp=16", n_rd); end
        n_vec++;
        if (n_vld !== 16) begin n_err++; $display("FAIL maxlen_vld got=%0d exp=16", n_vld); end
        n_vec++;
        if (n_done !== 1) begin n_err++; $display("FAIL maxlen_done got=%0d exp=1", n_done); end
    endtask

    task automatic test_abandon();
        int n_rd1   = 0;
        int n_vld1  = 0;
        int n_done1 = 0;
        int next_w  = -1;
        apply_reset();
        len0 = 4'd0;
        len1 = 4'd5;
        for (int k = 0; k < 12; k++) begin
            req1 = (k < 3) || (k >= 5 && k < 9);
            req0 = (k >= 5 && k < 9);
            model_eval();
            n_vec++;
            if (obs_vec() !== e_vec) begin
                n_err++;
                $display("FAIL abandon k=%0d got=%b exp=%b", k, obs_vec(), e_vec);
            end
            n_rd1   += int'(rd1);
            n_done1 += int'(done1);
            if (dout_vld && dout_id) n_vld1++;
            if (k >= 5 && fsm_rst && next_w < 0) next_w = gnt1 ? 1 : 0;
            advance();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        n_vec++;
        if (n_rd1 !== 2) begin n_err++; $display("FAIL abandon_rd1 got=%0d exp=2", n_rd1); end
        n_vec++;
        if (n_vld1 !== 2) begin n_err++; $display("FAIL abandon_vld got=%0d exp=2", n_vld1); end
        n_vec++;
        if (n_done1 !== 0) begin n_err++; $display("FAIL abandon_done1 got=%0d exp=0", n_done1); end
        n_vec++;
        if (next_w !== 0) begin n_err++; $display("FAIL abandon_next_tie got=%0d exp=0", next_w); end
    endtask

    task automatic test_reset_mid();
        int n_vld  = 0;
        int n_done = 0;
        bit seen   = 1'b0;
        apply_reset();
        len0 = 4'd7;
        for (int k = 0; k < 4; k++) begin
            req0 = 1'b1;
            req1 = 1'b0;
            model_eval();
            n_vec++;
            if (obs_vec() !== e_vec) begin
                n_err++;
                $display("FAIL rstmid_pre k=%0d got=%b exp=%b", k, obs_vec(), e_vec);
            end
            advance();
        end
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (obs_vec() !== 11'd0) begin
            n_err++;
            $display("FAIL rstmid_async got=%b exp=%b", obs_vec(), 11'd0);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (obs_vec() !== 11'd0) begin
            n_err++;
            $display("FAIL rstmid_hold got=%b exp=%b", obs_vec(), 11'd0);
        end
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 16; k++) begin
            req0 = !seen;
            req1 = 1'b0;
            model_eval();
            n_vec++;
            if (obs_vec() !== e_vec) begin
                n_err++;
                $display("FAIL rstmid_post k=%0d got=%b exp=%b", k, obs_vec(), e_vec);
            end
            if (dout_vld) n_vld++;
            if (done0) begin
                n_done++;
                seen = 1'b1;
            end
            advance();
        end
        n_vec++;
        if (n_vld !== 8) begin n_err++; $display("FAIL rstmid_vld got=%0d exp=8", n_vld); end
        n_vec++;
        if (n_done !== 1) begin n_err++; $display("FAIL rstmid_done got=%0d exp=1", n_done); end
    endtask

    task automatic test_random();
        bit pd0 = 1'b0;
        bit pd1 = 1'b0;
        apply_reset();
        for (int k = 0; k < 600; k++) begin
            if (!req0) begin
                if ($urandom_range(0, 2) == 0) req0 = 1'b1;
            end else if (pd0 ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 39) == 0)) begin
                req0 = 1'b0;
            end
            if (!req1) begin
                if ($urandom_range(0, 2) == 0) req1 = 1'b1;
            end else if (pd1 ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 39) == 0)) begin
                req1 = 1'b0;
            end
            len0 = 4'($urandom_range(0, 15));
            len1 = 4'($urandom_range(0, 15));
            model_eval();
            n_vec++;
            if (obs_vec() !== e_vec) begin
                n_err++;
                $display("FAIL random k=%0d got=%b exp=%b", k, obs_vec(), e_vec);
            end
            pd0 = done0;
            pd1 = done1;
            advance();
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        m_clr    = 0;
        m_gap    = 0;
        m_len    = 0;
        m_win    = 1'b0;
        m_par    = 1'b0;
        din_ones = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_tie();
        test_round_robin();
        test_max_len();
        test_abandon();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fsm_stream_arb.md
FSM_STREAM_ARB -- requirements
Module: fsm_stream_arb

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have ports req0/req1, input, 1 each, level request from requester 0/1, held until done or abandoned.
REQ-004 SHALL have ports len0/len1, input, 4 each, packet length minus one (value L = L+1 bits, 1..16), sampled at grant.
REQ-005 SHALL have ports din0/din1, input, 1 each, current serial bit from requester 0/1.
REQ-006 SHALL have ports gnt0/gnt1, output, 1 each, grant to requester 0/1, one-hot or zero.
REQ-007 SHALL have ports rd0/rd1, output, 1 each, bit-consumed strobe; requester advances to next bit after an edge where rd is high.
REQ-008 SHALL have ports fsm_rst (output, 1, active-high restart pulse), fsm_x (output, 1) and fsm_y (input, 1) to the shared serial FSM.
REQ-009 SHALL have ports dout, dout_vld, dout_id (output, 1 each): returned FSM output bit, valid, owning requester.
REQ-010 SHALL have ports done0/done1, output, 1 each, one-cycle completion pulse.

Function
REQ-011 SHALL implement states IDLE, CLR, RUN, GAP.
REQ-012 IDLE: if any req high at edge -> CLR, winner latched, its len latched into bit counter; else stay IDLE.
REQ-013 Arbitration SHALL be round-robin: single request wins; both high -> requester not served last wins.
REQ-014 CLR lasts exactly 1 cycle: fsm_rst=1, gnt of winner=1, fsm_x=0, rd=0; -> RUN.
REQ-015 RUN: gnt of winner=1, fsm_x = winner's din (combinational), rd of winner=1, counter decrements each cycle.
REQ-016 RUN SHALL last exactly L+1 cycles; after the cycle with counter=0 -> GAP.
REQ-017 At each RUN edge, fsm_y SHALL be registered into dout with dout_vld=1 and dout_id=winner (latency 1 cycle); dout_vld=0 otherwise.
REQ-018 GAP lasts 1 cycle: all gnt/rd=0, fsm_x=0, done of winner pulses 1, last-served updated; -> IDLE.
REQ-019 Minimum turnaround SHALL be L+4 cycles (IDLE, CLR, RUN x(L+1), GAP) per packet.
REQ-020 If winner's req drops during CLR or RUN: -> GAP next edge, no further rd/dout_vld, done NOT pulsed, last-served still updated.
REQ-021 Requests and len changes outside IDLE SHALL be ignored until return to IDLE.
REQ-022 fsm_x, gnt, rd SHALL be 0 in IDLE and GAP.

Reset
REQ-023 On reset low: state=IDLE, last-served=1 (req0 wins first tie), counter=0; gnt0/1, rd0/1, fsm_rst, fsm_x, dout, dout_vld, dout_id, done0/1 all 0.
REQ-024 Reset asserted mid-packet SHALL abort immediately with no done pulse; operation resumes from IDLE after release.

Configuration
REQ-025 Macro FSM_ARB_FIXED_PRIO_EN: defined -> req0 always wins ties (fixed priority, last-served unused); undefined -> round-robin per REQ-013.

Verification
REQ-026 Reset, req0=1 len0=3 din0 stream 1,1,1,1 -> fsm_rst 1 cycle, 4 rd0 pulses, 4 dout_vld with dout_id=0, done0 once, total 7 cycles req-to-done.
REQ-027 req0=req1=1 from reset, len=0 both -> req0 served first, then req1; done0 then done1, gnt never both high.
REQ-028 Both requesting continuously (len=1) -> grants alternate 0,1,0,1 (round-robin); with FSM_ARB_FIXED_PRIO_EN -> always 0.
REQ-029 len0=15 -> exactly 16 RUN cycles and 16 dout_vld pulses, counter wraps to IDLE cleanly.
REQ-030 req1 dropped on 2nd RUN cycle (len1=5) -> GAP next cycle, dout_vld stops after 2, no done1, next tie goes to req0.
REQ-031 reset driven low during RUN -> all outputs 0 asynchronously, no done; after release req0 packet completes normally.
